axis_upsizer: RTL

Stream width upsizer that sits directly downstream of the 4-bit register-slice buffer and consumes its tvalid/tready/tdata stream. It packs RATIO consecutive narrow beats into one wide word. Packing is LSB-first. It presents the word on a registered valid/ready output. Full throughput is kept: one narrow beat per cycle, including the cycle in which a finished word drains.

---
 rtl/axis_pkg.sv | 15 +
 rtl/axis_upsizer.sv | 65 ++++++
 2 files changed

// File: rtl/axis_pkg.sv
// Stream constants shared by the register-slice buffer and the width upsizer.
package axis_pkg;

  // Narrow stream width used by the register-slice buffer.
  localparam int AXIS_DATA_W = 4;

  // Default packing ratio for the upsizer.
  localparam int AXIS_UPSIZE_RATIO = 4;

  // Width of the packed word for a given narrow width and ratio.
  function automatic int axis_wide_w(input int data_w, input int ratio);
    return data_w * ratio;
  endfunction

endpackage

// File: rtl/axis_upsizer.sv
// Packs RATIO consecutive narrow beats (LSB-first) into one wide word
// presented on a registered valid/ready output, at one beat per cycle.
module axis_upsizer
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int RATIO = AXIS_UPSIZE_RATIO,
  localparam int CNT_W = $clog2(RATIO)
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    tvalid_i,
  output logic                    tready_o,
  input  logic [DATA_W-1:0]       tdata_i,
  input  logic                    tready_i,
  output logic                    tvalid_o,
  output logic [DATA_W*RATIO-1:0] tdata_o,
  output logic [CNT_W-1:0]        beat_cnt_o
);

  localparam int ACC_W = (RATIO - 1) * DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             last_beat;
  logic             in_hs;
  logic             out_hs;

  // Stall only when the incoming beat would complete a word while the
  // previous word is still waiting downstream.
  always_comb begin
    last_beat = (cnt == LAST_CNT);
    tready_o  = ~tvalid_o | tready_i | ~last_beat;
    in_hs     = tvalid_i & tready_o;
    out_hs    = tvalid_o & tready_i;
  end

  // Beat counter, assembly register and registered output word.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt      <= '0;
      acc      <= '0;
      tdata_o  <= '0;
      tvalid_o <= 1'b0;
    end else begin
      if (in_hs && last_beat) begin
        tdata_o  <= {tdata_i, acc};
        tvalid_o <= 1'b1;
        cnt      <= '0;
      end else begin
        if (in_hs) begin
          acc[cnt*DATA_W +: DATA_W] <= tdata_i;
          cnt                       <= cnt + 1'b1;
        end
        if (out_hs) begin
          tvalid_o <= 1'b0;
        end
      end
    end
  end

  assign beat_cnt_o = cnt;

endmodule
